// File: rtl/comp_serial_msb_if.sv
// Operand/result handshake bundle for the MSB-first serial comparator.
// slave = comparator side, master = producer/consumer side.
interface comp_serial_msb_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             lt;
    logic             gt;
    logic             eq;
    logic             busy;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, lt, gt, eq, busy
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, lt, gt, eq, busy
    );
endinterface

// File: rtl/comp_serial_msb.sv
// Unsigned magnitude compare, one DIGIT slice per clock from the MSB down; result is lt/gt/eq one-hot.
// Latency: NUM_DIGITS cycles; with COMP_SERIAL_EARLY_EXIT_EN, p cycles (p = first differing digit from MSB).
// Backpressure: operands accepted only in IDLE; the result is held in DONE until out_ready.
module comp_serial_msb #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    comp_serial_msb_if.slave   bus
);
    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int IDXW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPARE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_width_check
            $error("comp_serial_msb: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             lt_q;
    logic             gt_q;
    logic             eq_q;
    logic [DIGIT-1:0] sa;
    logic [DIGIT-1:0] sb;

    assign sa = a_q[int'(idx) * DIGIT +: DIGIT];
    assign sb = b_q[int'(idx) * DIGIT +: DIGIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= IDXW'(NUM_DIGITS - 1);
            a_q   <= '0;
            b_q   <= '0;
            lt_q  <= 1'b0;
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        idx   <= IDXW'(NUM_DIGITS - 1);
                        lt_q  <= 1'b0;
                        gt_q  <= 1'b0;
                        eq_q  <= 1'b0;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
`ifdef COMP_SERIAL_EARLY_EXIT_EN
                    if (sa > sb) begin
                        gt_q  <= 1'b1;
                        state <= DONE;
                    end else if (sa < sb) begin
                        lt_q  <= 1'b1;
                        state <= DONE;
                    end else if (idx == '0) begin
                        eq_q  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
`else
                    // First mismatch is sticky; the walk always covers every digit.
                    if (!lt_q && !gt_q) begin
                        if (sa > sb) begin
                            gt_q <= 1'b1;
                        end else if (sa < sb) begin
                            lt_q <= 1'b1;
                        end
                    end
                    if (idx == '0) begin
                        if (!lt_q && !gt_q && (sa == sb)) begin
                            eq_q <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        lt_q  <= 1'b0;
                        gt_q  <= 1'b0;
                        eq_q  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == COMPARE) || (state == DONE);
    assign bus.lt        = lt_q;
    assign bus.gt        = gt_q;
    assign bus.eq        = eq_q;
endmodule
